// File: rtl/vga_pkg.sv
// Shared VGA / framebuffer constants, CPU arbiter FSM encoding and the
// scanout fetch address helper. Also used by vga_gen.
package vga_pkg;

    localparam int unsigned WORDS_PER_LINE = 64;
    localparam int unsigned VISIBLE_LINES  = 768;
    localparam int unsigned PIX_PER_WORD   = 16;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned LINE_W     = 10;
    localparam int unsigned PIX_W      = 10;
    localparam int unsigned WORD_IDX_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned PHASE_W    = $clog2(PIX_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GO   = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } cpu_state_e;

    // Latched CPU request payload
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cpu_cmd_t;

    // Address of the word following the one under the given pixel on the
    // given line; the last word of a line rolls to word 0 of the next line,
    // and the last visible line rolls to line 0.
    function automatic logic [ADDR_W-1:0] fetch_addr(
        input logic [ADDR_W-1:0] base,
        input logic [LINE_W-1:0] line,
        input logic [PIX_W-1:0]  pix
    );
        logic [WORD_IDX_W-1:0] cur_word;
        logic [WORD_IDX_W-1:0] word;
        logic [LINE_W-1:0]     ln;
        cur_word = pix[PIX_W-1:PHASE_W];
        word     = cur_word + WORD_IDX_W'(1);
        ln       = line;
        if (cur_word == WORD_IDX_W'(WORDS_PER_LINE - 1)) begin
            ln = (line == LINE_W'(VISIBLE_LINES - 1)) ? '0 : line + LINE_W'(1);
        end
        return base + (ADDR_W'(ln) << WORD_IDX_W) + ADDR_W'(word);
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// CPU load/store bus into the framebuffer arbiter.
//   master: CPU side (drives cpu_req/cpu_we/cpu_addr/cpu_wdata)
//   slave : arbiter side (drives cpu_ack/cpu_rdata)
interface fb_arbiter_if;
    import vga_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/fb_arbiter_pix_shifter.sv
// Captures the prefetched framebuffer word and serialises it MSB first.
//   clk, rst  : pixel clock, synchronous active-high reset
//   avr       : active video region
//   phase     : pixel_num[3:0]
//   slot      : scanout fetch issued this cycle
//   mem_rdata : VRAM read data (valid the cycle after slot)
//   pixel_out : registered 1 bpp pixel
module pix_shifter
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               avr,
    input  logic [PHASE_W-1:0] phase,
    input  logic               slot,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               pixel_out
);

    logic              slot_d;
    logic [DATA_W-1:0] next_word;
    logic [DATA_W-1:0] shreg;
    logic              load;

    assign load = (phase == '0);

    // pixel_out follows the register contents after this cycle's load/shift,
    // so the MSB of a freshly loaded word appears one cycle after phase 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_d    <= 1'b0;
            next_word <= '0;
            shreg     <= '0;
            pixel_out <= 1'b0;
        end else begin
            slot_d <= slot;
            if (slot_d) begin
                next_word <= mem_rdata;
            end
            if (avr) begin
                if (load) begin
                    shreg     <= next_word;
                    pixel_out <= next_word[DATA_W-1];
                end else begin
                    shreg     <= shreg << 1;
                    pixel_out <= shreg[DATA_W-2];
                end
            end else begin
                pixel_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// VRAM arbiter: scanout prefetch has absolute priority on its slot, CPU
// load/store requests use the remaining cycles; drives the pixel shifter.
//   clk, rst            : pixel clock, synchronous active-high reset
//   avr/line_num/pixel_num : scanout position from vga_gen
//   cpu                 : CPU request bus (slave side)
//   mem_*               : single-port VRAM port (combinational)
//   pixel_out           : registered monochrome pixel
module fb_arbiter
    import vga_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  FB_BASE = 16'h0000,
    parameter logic [PHASE_W-1:0] PF_SLOT = 4'd8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              avr,
    input  logic [LINE_W-1:0] line_num,
    input  logic [PIX_W-1:0]  pixel_num,
    fb_arbiter_if.slave       cpu,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pixel_out
);

    cpu_state_e state;
    cpu_cmd_t   cmd;
    logic       slot_c;

    assign slot_c = avr && (pixel_num[PHASE_W-1:0] == PF_SLOT);

    // CPU access FSM; GO waits out any scanout slot before using the port
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cmd           <= '0;
            cpu.cpu_ack   <= 1'b0;
            cpu.cpu_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cpu.cpu_ack <= 1'b0;
                    if (cpu.cpu_req) begin
                        cmd.we    <= cpu.cpu_we;
                        cmd.addr  <= cpu.cpu_addr;
                        cmd.wdata <= cpu.cpu_wdata;
                        state     <= ST_GO;
                    end
                end
                ST_GO: begin
                    if (!slot_c) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!cmd.we) begin
                        cpu.cpu_rdata <= mem_rdata;
                    end
                    cpu.cpu_ack <= 1'b1;
                    state       <= ST_ACK;
                end
                ST_ACK: begin
                    cpu.cpu_ack <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    cpu.cpu_ack <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory port mux; address/data rest on the last CPU command when idle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cmd.addr;
        mem_wdata = cmd.wdata;
        if (!rst) begin
            if (slot_c) begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr(FB_BASE, line_num, pixel_num);
            end else if (state == ST_GO) begin
                mem_en = 1'b1;
                mem_we = cmd.we;
            end
        end
    end

    pix_shifter u_pix_shifter (
        .clk       (clk),
        .rst       (rst),
        .avr       (avr),
        .phase     (pixel_num[PHASE_W-1:0]),
        .slot      (slot_c),
        .mem_rdata (mem_rdata),
        .pixel_out (pixel_out)
    );

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a 1-cycle synchronous VRAM model.
module tb_fb_arbiter;
    import vga_pkg::*;

    localparam logic [15:0] TB_BASE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        avr;
    logic [9:0]  line_num;
    logic [9:0]  pixel_num;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        pixel_out;

    int checks   = 0;
    int failures = 0;

    fb_arbiter_if bus();

    fb_arbiter #(.FB_BASE(TB_BASE), .PF_SLOT(4'd8)) dut (
        .clk       (clk),
        .rst       (rst),
        .avr       (avr),
        .line_num  (line_num),
        .pixel_num (pixel_num),
        .cpu       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pixel_out (pixel_out)
    );

    always #5 clk = ~clk;

    logic [15:0] vram [65536];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            mem_rdata <= vram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic exp_pix(input logic [9:0] line, input logic [9:0] pix);
        logic [15:0] a;
        logic [15:0] w;
        logic [3:0]  b;
        a = TB_BASE + (16'(line) << 6) + 16'(pix[9:4]);
        w = vram[a];
        b = 4'd15 - pix[3:0];
        return w[b];
    endfunction

    // Drive one visible line from pixel 0; optionally inject a CPU read
    // of 0x1234 whose GO cycle lands on the scanout slot.
    task automatic run_line(input logic [9:0] line, input int npix, input bit contend);
        avr      = 1'b1;
        line_num = line;
        for (int p = 0; p < npix; p++) begin
            @(negedge clk);
            if (p >= 17) check($sformatf("pix%0d", p - 1), 32'(pixel_out), 32'(exp_pix(line, 10'(p - 1))));
            if (contend) begin
                if (p == 7) begin
                    bus.cpu_req  = 1'b1;
                    bus.cpu_we   = 1'b0;
                    bus.cpu_addr = 16'h1234;
                end
                if (p == 10) check("cont_ack_early", 32'(bus.cpu_ack), 32'd0);
                if (p == 11) begin
                    check("cont_ack", 32'(bus.cpu_ack), 32'd1);
                    check("cont_rdata", 32'(bus.cpu_rdata), 32'hBEEF);
                    bus.cpu_req = 1'b0;
                end
            end
            pixel_num = 10'(p);
            #1;
            if (p == 40) begin
                check("slot40_en", 32'(mem_en), 32'd1);
                check("slot40_we", 32'(mem_we), 32'd0);
                check("slot40_addr", 32'(mem_addr), 32'(TB_BASE + (16'(line) << 6) + 16'd3));
            end
            if (contend && p == 8) begin
                check("cont8_en", 32'(mem_en), 32'd1);
                check("cont8_we", 32'(mem_we), 32'd0);
                check("cont8_addr", 32'(mem_addr), 32'(TB_BASE + (16'(line) << 6) + 16'd1));
            end
            if (contend && p == 9) begin
                check("cont9_en", 32'(mem_en), 32'd1);
                check("cont9_addr", 32'(mem_addr), 32'h1234);
            end
        end
        @(negedge clk);
        check($sformatf("pix%0d", npix - 1), 32'(pixel_out), 32'(exp_pix(line, 10'(npix - 1))));
        avr = 1'b0;
    endtask

    // Full CPU access with a bounded wait for the ack
    task automatic cpu_xfer(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output int lat);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            lat = i;
            if (bus.cpu_ack) break;
        end
        if (!bus.cpu_ack) check("ack_timeout", 32'(bus.cpu_ack), 32'd1);
        rdata       = bus.cpu_rdata;
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        int          lat;
        bit          seen_ack;

        for (int i = 0; i < 65536; i++) vram[i] = 16'h0000;
        vram[16'h0141] = 16'h8001;
        vram[16'h0142] = 16'h0F0F;
        vram[16'h0143] = 16'hA5F0;
        vram[16'h0144] = 16'h3C3C;
        vram[16'h0200] = 16'h5555;

        // Reset with a pending request and the slot decode active
        rst           = 1'b1;
        avr           = 1'b1;
        line_num      = 10'd0;
        pixel_num     = 10'd8;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_pixel", 32'(pixel_out), 32'd0);
        rst = 1'b0;
        avr = 1'b0;
        #1;
        check("post_rst_idle_en", 32'(mem_en), 32'd0);
        check("post_rst_ack", 32'(bus.cpu_ack), 32'd0);
        // The held request now completes as a read of word 0
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) break;
        end
        check("post_rst_read_ack", 32'(bus.cpu_ack), 32'd1);
        bus.cpu_req = 1'b0;
        @(negedge clk);

        // Scanout of line 5, pixels 0..79
        run_line(10'd5, 80, 1'b0);

        // Fetch address wrap at the end of a line and of the frame
        @(negedge clk);
        avr       = 1'b1;
        line_num  = 10'd10;
        pixel_num = 10'd1016;
        #1;
        check("wrap_line_en", 32'(mem_en), 32'd1);
        check("wrap_line_addr", 32'(mem_addr), 32'h02C0);
        @(negedge clk);
        line_num = 10'd767;
        #1;
        check("wrap_frame_addr", 32'(mem_addr), 32'h0000);
        @(negedge clk);
        avr       = 1'b0;
        pixel_num = 10'd0;
        line_num  = 10'd0;
        repeat (2) @(negedge clk);

        // Uncontended write: memory cycle 1, ack cycle 3
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 16'h1234;
        bus.cpu_wdata = 16'hBEEF;
        #1;
        check("wr_c0_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        #1;
        check("wr_c1_en", 32'(mem_en), 32'd1);
        check("wr_c1_we", 32'(mem_we), 32'd1);
        check("wr_c1_addr", 32'(mem_addr), 32'h1234);
        check("wr_c1_wdata", 32'(mem_wdata), 32'hBEEF);
        @(negedge clk);
        check("wr_c2_ack", 32'(bus.cpu_ack), 32'd0);
        @(negedge clk);
        check("wr_c3_ack", 32'(bus.cpu_ack), 32'd1);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("wr_c4_ack", 32'(bus.cpu_ack), 32'd0);
        check("wr_vram", 32'(vram[16'h1234]), 32'hBEEF);

        // Read-back
        cpu_xfer(1'b0, 16'h1234, 16'h0000, rd, lat);
        check("rd_lat", 32'(lat), 32'd3);
        check("rd_data", 32'(rd), 32'hBEEF);
        @(negedge clk);

        // Read contending with the scanout slot
        run_line(10'd5, 48, 1'b1);
        repeat (2) @(negedge clk);

        // Reset during GO of a write
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 16'h0200;
        bus.cpu_wdata = 16'hDEAD;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_go_we", 32'(mem_we), 32'd0);
        check("rst_go_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) seen_ack = 1'b1;
        end
        check("rst_go_no_ack", 32'(seen_ack), 32'd0);
        check("rst_go_vram", 32'(vram[16'h0200]), 32'h5555);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Shares the single-port video RAM between the VGA scanout path and CPU load/store requests, and turns fetched framebuffer words into a 1 bpp pixel stream. Sits between `vga_gen` (consumes its `avr`, `line_num`, `pixel_num`), the CPU bus and the VRAM macro. Scanout has absolute priority: it owns one fixed memory slot per 16 visible pixels. The CPU gets every other cycle.

## Interface
- `FB_BASE`, default 16'h0000: VRAM word address of line 0, word 0.
- `PF_SLOT`, default 4'd8: value of `pixel_num[3:0]` at which the scanout fetch is issued. Legal range 0–14.
- `clk` in 1: 75 MHz pixel clock, the same clock as `vga_gen`.
- `rst` in 1: synchronous, active-high reset.
- `avr` in 1: active video region from `vga_gen`.
- `line_num` in 10: visible line, 0–767.
- `pixel_num` in 10: visible pixel, 0–1023.
- `cpu_req` in 1: CPU access request. Held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read. Sampled with `cpu_req`.
- `cpu_addr` in 16: VRAM word address.
- `cpu_wdata` in 16: write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 16: read data. Valid while `cpu_ack`=1 and held until the next read completes.
- `mem_en` out 1: VRAM cycle enable.
- `mem_we` out 1: VRAM write enable.
- `mem_addr` out 16: VRAM word address.
- `mem_wdata` out 16: VRAM write data.
- `mem_rdata` in 16: VRAM read data. Valid the cycle after an `mem_en` read (1-cycle synchronous SRAM).
- `pixel_out` out 1: monochrome pixel, MSB of each word first.

## Operation
- Framebuffer layout: 64 words per line, 16 pixels per word. Word address = `FB_BASE + line*64 + word`, 16-bit wrap.
- Scanout slot:
  - Occurs when `avr` && `pixel_num[3:0]==PF_SLOT`.
  - Drives `mem_en`=1, `mem_we`=0.
  - Address is word `pixel_num[9:4]+1` of `line_num`.
  - Word 63 wraps to word 0 of `line_num+1`. Line 767 wraps to line 0.
- A registered `slot_d` flag captures `mem_rdata` into `next_word` on the cycle after the slot.
- Shift register:
  - On a cycle with `avr` && `pixel_num[3:0]==0`, it loads `next_word`.
  - On other `avr` cycles it shifts left.
- CPU FSM, states IDLE, GO, DATA, ACK:
  - IDLE: if `cpu_req`, latch `cpu_we`/`cpu_addr`/`cpu_wdata` and go to GO.
  - GO, slot cycle: stay in GO; the memory port carries the scanout access.
  - GO, otherwise: drive `mem_en`=1, `mem_we`=latched we, latched addr/wdata, then go to DATA.
  - DATA: if read, `cpu_rdata` <= `mem_rdata`. Go to ACK.
  - ACK: `cpu_ack`=1, then go to IDLE. A new request is sampled in the following IDLE cycle.
- Memory port muxing:
  - `mem_*` are combinational from the slot decode and FSM state.
  - Slot and GO never share a memory cycle.
  - When neither is active, `mem_en`=`mem_we`=0 and `mem_addr`/`mem_wdata` hold the last CPU values.
  - `mem_en` and `mem_we` are forced to 0 while `rst`=1.
- The CPU address is passed through unchecked; writes may target the visible framebuffer at any time.

## Timing
- Reset values:
  - FSM IDLE.
  - `cpu_ack`=0, `cpu_rdata`=0.
  - `next_word`=0, shift register 0, `slot_d`=0, `pixel_out`=0.
- Until the first scanout fetch after reset, the 16 pixels it covers (line 0, word 0 of the first frame) read as 0.
- Pixel latency: `pixel_out` at cycle t+1 = bit (15−`pixel_num[3:0]`) of the word for the `pixel_num`/`line_num` presented at cycle t. It is 0 if `avr` was 0 at t.
- Fetch-to-use: slot at pixel k*16+`PF_SLOT` → captured at +1 → displayed from pixel (k+1)*16.
- CPU latency:
  - Uncontended: `cpu_req` in IDLE at cycle 0 → memory cycle 1 → `cpu_ack` cycle 3.
  - Contended: each slot hit in GO adds one cycle.
- Reset mid-transaction (any state): the FSM returns to IDLE, no `cpu_ack` is issued, a pending write is dropped, and the requester must re-issue.
- `cpu_req` deasserted before ack: undefined. The bench must not do it.

## Structure
- Shared package `vga_pkg`:
  - `WORDS_PER_LINE`=64, `VISIBLE_LINES`=768, `PIX_PER_WORD`=16.
  - CPU FSM state encoding.
  - These constants are shared with `vga_gen`.
- One sub-module, `pix_shifter`: `next_word` capture, 16-bit shift register, `pixel_out` register.
- The arbitration FSM stays in `fb_arbiter`.

## Test plan
- Reset with `cpu_req`=1, `avr`=1 → all outputs 0 while `rst`=1. IDLE with `cpu_ack`=0 on the first post-reset cycle.
- Memory model holds word 0x0143 = 16'hA5F0; drive `line_num`=5 with `avr` → `mem_addr`=0x0143 with `mem_en`=1 at `pixel_num`=40. Pixels 48–63 produce `pixel_out` 1010010111110000, each one cycle late.
- `line_num`=10, `pixel_num`=1016, `avr`=1 → `mem_addr`=0x02C0. `line_num`=767, `pixel_num`=1016 → `mem_addr`=0x0000.
- `avr`=0, CPU write 0x1234 ← 16'hBEEF at cycle 0 → `mem_en`=`mem_we`=1, addr 0x1234, data 0xBEEF at cycle 1. `cpu_ack` at cycle 3. A subsequent read of 0x1234 returns 16'hBEEF with its ack.
- CPU read timed so GO coincides with `pixel_num`=8, `avr`=1 → that cycle carries the scanout address with `mem_we`=0. The CPU access follows at `pixel_num`=9 and `cpu_ack` comes 4 cycles after the request. The displayed pixels are unaffected.
- `rst` asserted during GO of a write → `mem_we` stays 0, no `cpu_ack` ever issued, target word unchanged.
